// File: rtl/rca_seq_pkg.sv
// Purpose: shared types and constants for the nibble-serial ripple-carry adder controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the controller state enumeration and the width of the shared adder slice.
package rca_seq_pkg;

  // Width of the shared combinational adder slice, in bits.
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rca_state_e;

endpackage

// File: rtl/nibble_adder.sv
// Purpose: 4-bit combinational ripple-carry adder slice.
// Latency: purely combinational, zero cycles.
// Backpressure: none (no handshake).
//
// Ports:
//   A, B   : NIB_W-bit addends
//   c_in   : carry into bit 0
//   S      : NIB_W-bit sum
//   c_out  : carry out of the top bit
module nibble_adder
  import rca_seq_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             c_in,
  output logic [NIB_W-1:0] S,
  output logic             c_out
);

  always_comb begin : ripple
    logic [NIB_W:0] carry;
    carry    = '0;
    S        = '0;
    carry[0] = c_in;
    for (int i = 0; i < NIB_W; i++) begin
      S[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
    end
    c_out = carry[NIB_W];
  end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Purpose: WIDTH-bit add/subtract computed one nibble per clock through a single 4-bit slice.
// Latency: res_valid rises WIDTH/4 clock edges after the accepting edge.
// Backpressure: result is held in DONE until res_ready; start_ready is low outside IDLE.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start_valid/ready    : operation request handshake; A, B, c_in, op sampled on acceptance
//   A, B                 : WIDTH-bit operands
//   c_in                 : carry-in (borrow-in when subtracting)
//   op                   : 0 = add, 1 = subtract
//   res_valid/ready      : result handshake
//   S, c_out             : result and final carry (subtract: c_out=1 means no borrow)
//   busy                 : high while an operation is in flight or its result is pending
//
// Build option: define RCA_SEQ_SUB_EN to honour op; otherwise op is ignored and every
// operation is an add (no operand inversion logic is built).
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  input  logic             op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  rca_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  // Second operand is stored already conditioned (inverted for subtract), so the
  // RUN datapath never needs to know which operation is in flight.
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;

  // Operand conditioning applied at acceptance time.
  logic [WIDTH-1:0] b_in;
  logic             cin_in;

`ifdef RCA_SEQ_SUB_EN
  // A - B - c_in == A + ~B + ~c_in (mod 2^WIDTH); the carry-out then reads as "no borrow".
  assign b_in   = op ? ~B : B;
  assign cin_in = op ? ~c_in : c_in;
`else
  assign b_in   = B;
  assign cin_in = c_in;
  logic unused_op;
  assign unused_op = op;
`endif

  // Shared slice operates on the nibble selected by idx_q.
  logic [NIB_W-1:0] nib_a, nib_b, nib_s;
  logic             nib_co;

  assign nib_a = a_q[idx_q*NIB_W +: NIB_W];
  assign nib_b = b_q[idx_q*NIB_W +: NIB_W];

  nibble_adder u_nibble_adder (
    .A     (nib_a),
    .B     (nib_b),
    .c_in  (carry_q),
    .S     (nib_s),
    .c_out (nib_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    cout_d      = cout_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          a_d     = A;
          b_d     = b_in;
          carry_d = cin_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        busy = 1'b1;
        // Only the current nibble of S is overwritten; earlier nibbles keep this
        // operation's results and later ones still show the previous result.
        s_d[idx_q*NIB_W +: NIB_W] = nib_s;
        carry_d = nib_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = nib_co;
          idx_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign S     = s_q;
  assign c_out = cout_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Purpose: self-checking bench for rca_seq_ctrl (WIDTH=16) with a scoreboard and arithmetic model.
// Latency: checks res_valid rises exactly 4 edges after each accepting edge.
// Backpressure: exercises held results under res_ready=0 and random res_ready.
module tb_rca_seq_ctrl;

  localparam int W = 16;
  localparam int LAT = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         c_in;
  logic         op;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] S;
  logic         c_out;
  logic         busy;

  always #5 clk = ~clk;

  rca_seq_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .A           (A),
    .B           (B),
    .c_in        (c_in),
    .op          (op),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .S           (S),
    .c_out       (c_out),
    .busy        (busy)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
  } res_t;

  res_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic prev_rv = 1'b0;
  logic rr_random = 1'b0;
  res_t last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub);
    res_t r;
    longint unsigned ua, ub, uc, t;
    ua = longint'(a);
    ub = longint'(b);
    uc = longint'(ci);
    if (sub) begin
      t   = ua - ub - uc;
      r.s = W'(t);
      r.c = (ua >= ub + uc);
    end else begin
      t   = ua + ub + uc;
      r.s = W'(t);
      r.c = t[W];
    end
    return r;
  endfunction

  // Stimulus side of the scoreboard: every accepted request pushes its expected result.
  always @(posedge clk) begin
    logic sub;
    cyc = cyc + 1;
`ifdef RCA_SEQ_SUB_EN
    sub = op;
`else
    sub = 1'b0;
`endif
    if (rst_n && start_valid && start_ready) begin
      exp_q.push_back(model(A, B, c_in, sub));
      acc_q.push_back(cyc);
    end
  end

  // Monitor: compares whatever the DUT presents against the head of the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rv = 1'b0;
    end else begin
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_res_valid", 32'(res_valid), 32'd0);
        end else begin
          if (!prev_rv) check("latency", 32'(cyc - acc_q[0]), 32'(LAT));
          check("S", 32'(S), 32'(exp_q[0].s));
          check("c_out", 32'(c_out), 32'(exp_q[0].c));
          check("busy_done", 32'(busy), 32'd1);
          check("start_ready_done", 32'(start_ready), 32'd0);
          if (res_ready) begin
            last_res = exp_q.pop_front();
            void'(acc_q.pop_front());
          end
        end
      end
      prev_rv = res_valid && !res_ready;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rr_random) res_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic o);
    int n;
    n = 0;
    while (!start_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!start_ready) begin
      check("start_ready_timeout", 32'(start_ready), 32'd1);
      return;
    end
    A = a; B = b; c_in = ci; op = o;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    // Scramble the operand pins while the operation is in flight.
    A = W'($urandom); B = W'($urandom);
    c_in = 1'($urandom); op = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_S"}, 32'(S), 32'd0);
    check({tag, "_c_out"}, 32'(c_out), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    start_valid = 1'b0;
    A = '0; B = '0; c_in = 1'b0; op = 1'b0;
    res_ready = 1'b1;
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, including inter-nibble carry and full-width overflow.
    issue(16'h0001, 16'h0003, 1'b0, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    issue(16'h0005, 16'h0003, 1'b0, 1'b1);
    issue(16'h0003, 16'h0005, 1'b0, 1'b1);
    issue(16'h8000, 16'h0001, 1'b1, 1'b1);
    drain();

    // Result must persist in IDLE after the handshake.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_idle_S", 32'(S), 32'(last_res.s));
    check("hold_idle_c_out", 32'(c_out), 32'(last_res.c));
    check("idle_start_ready", 32'(start_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Backpressure: hold the result and poke start_valid meanwhile.
    res_ready = 1'b0;
    issue(16'h1234, 16'h4321, 1'b1, 1'b0);
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_res_valid_seen", 32'(res_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      start_valid = (i == 2);
      check("bp_start_ready", 32'(start_ready), 32'd0);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_res_valid_dropped", 32'(res_valid), 32'd0);
    check("bp_start_ready_back", 32'(start_ready), 32'd1);
    drain();

    // Reset in the middle of RUN (idx=2): operation is discarded.
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("abort_no_res_valid", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
    end
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
    drain();

    // Random operations with random consumer backpressure.
    rr_random = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();
    rr_random = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rca_seq_ctrl.md
RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port start_valid, input, 1, requester presents an operation.
REQ-005 Port start_ready, output, 1, block can accept an operation.
REQ-006 Port A, input, WIDTH, first operand; sampled on the accepting edge.
REQ-007 Port B, input, WIDTH, second operand; sampled on the accepting edge.
REQ-008 Port c_in, input, 1, carry-in (borrow-in when subtracting); sampled on the accepting edge.
REQ-009 Port op, input, 1, 0 = add, 1 = subtract; sampled on the accepting edge.
REQ-010 Port res_valid, output, 1, S and c_out hold a completed result.
REQ-011 Port res_ready, input, 1, consumer accepts the result.
REQ-012 Port S, output, WIDTH, sum/difference.
REQ-013 Port c_out, output, 1, final carry-out (for subtract: 1 = no borrow).
REQ-014 Port busy, output, 1, high in RUN and DONE.

Function
REQ-015 The block SHALL compute the WIDTH-bit result nibble-serially through one shared 4-bit adder slice, LSB nibble first, one nibble per clock.
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 IDLE: start_ready=1; on start_valid&&start_ready, capture A, B, op; carry register <= c_in (add) or ~c_in (subtract); nibble index <= 0; go to RUN.
REQ-018 RUN: start_ready=0; each edge adds nibble[idx] of A and B' (B' = B for add, ~B for subtract) plus the carry register, writes S[idx], updates the carry, and increments idx.
REQ-019 On the edge that processes idx = WIDTH/4-1, the block SHALL load c_out from the final carry and go to DONE.
REQ-020 Latency: res_valid SHALL rise exactly WIDTH/4 rising edges after the accepting edge.
REQ-021 DONE: res_valid=1; S and c_out stable; on res_ready go to IDLE, with res_valid=0 from the next cycle.
REQ-022 start_ready SHALL be 1 only in IDLE; start_valid outside IDLE is ignored and no operation is queued.
REQ-023 Changes on A, B, c_in, op after acceptance SHALL NOT affect the in-flight result.
REQ-024 After the result handshake, S and c_out SHALL hold their values until the next accepted operation's first RUN edge.
REQ-025 A result held under res_ready=0 SHALL be held indefinitely without corruption.
REQ-026 Subtract: S = (A - B - c_in) mod 2^WIDTH.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, idx=0, carry=0, S=0, c_out=0, res_valid=0, busy=0, start_ready=1.
REQ-028 Reset asserted during RUN or DONE SHALL discard the operation; no res_valid follows.

Configuration
REQ-029 Macro RCA_SEQ_SUB_EN defined: op SHALL be honoured as in REQ-017, REQ-018 and REQ-026.
REQ-030 Macro RCA_SEQ_SUB_EN undefined: the op port SHALL remain present but be ignored; every operation is an add, and no B-inversion logic is built.

Structure
REQ-031 Package rca_seq_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the nibble width constant (4).
REQ-032 The 4-bit combinational ripple slice SHALL be a separate sub-module named nibble_adder (ports A, B, c_in, S, c_out), instantiated once.

Verification (WIDTH=16)
REQ-033 Add 0x0001 + 0x0003, c_in=0 -> S=0x0004, c_out=0; res_valid 4 edges after acceptance.
REQ-034 Add 0xFFFF + 0xFFFF, c_in=1 -> S=0xFFFF, c_out=1; 0x0F0F + 0x00F1, c_in=0 -> S=0x1000, c_out=0 (inter-nibble carry).
REQ-035 Backpressure: hold res_ready=0 for 5 cycles after res_valid and pulse start_valid meanwhile -> S and c_out stable, start_ready=0, the pulse is not accepted.
REQ-036 Assert rst_n=0 at RUN idx=2, then release -> all outputs at reset values, no res_valid; the next add completes correctly.
REQ-037 With RCA_SEQ_SUB_EN: 0x0005 - 0x0003, c_in=0 -> 0x0002, c_out=1; 0x0003 - 0x0005 -> 0xFFFE, c_out=0.
REQ-038 Without RCA_SEQ_SUB_EN: op=1, 0x0005 and 0x0003 -> S=0x0008, c_out=0.
